// File: rtl/pipeline_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg : shared widths and write-back source encodings for the pipeline
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef enum logic [1:0] {
    RF_WR_SEL_NONE = 2'b00,
    RF_WR_SEL_PC4  = 2'b01,
    RF_WR_SEL_ALU  = 2'b10,
    RF_WR_SEL_MEM  = 2'b11
  } rf_wr_sel_e;

endpackage

`default_nettype wire

// File: rtl/regfile_2r1w.sv
// ---------------------------------------------------------------------------
// regfile_2r1w : NREG x XLEN register file, two read ports, one write port
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_2r1w
  import pipeline_pkg::*;
#(
  parameter int RF_XLEN = 64,
  parameter int RF_NREG = 32,
  parameter int RF_AW   = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RF_AW-1:0]   ra1,
  input  logic [RF_AW-1:0]   ra2,
  input  logic               we,
  input  logic [RF_AW-1:0]   wa,
  input  logic [RF_XLEN-1:0] wd,
  output logic [RF_XLEN-1:0] rd1,
  output logic [RF_XLEN-1:0] rd2
);

  logic [RF_XLEN-1:0] regs [RF_NREG];

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < RF_NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != '0)) begin
      regs[wa] <= wd;
    end
  end

  // Write-first: a same-cycle write to the addressed register is seen by the reader.
  function automatic logic [RF_XLEN-1:0] rd_port(
    input logic [RF_AW-1:0]   ra,
    input logic               w_en,
    input logic [RF_AW-1:0]   w_addr,
    input logic [RF_XLEN-1:0] w_data,
    input logic [RF_XLEN-1:0] stored
  );
    if (ra == '0)                        return '0;
    else if (w_en && (w_addr == ra))     return w_data;
    else                                 return stored;
  endfunction

  assign rd1 = rd_port(ra1, we, wa, wd, regs[ra1]);
  assign rd2 = rd_port(ra2, we, wa, wd, regs[ra2]);

endmodule

`default_nettype wire

// File: rtl/pipeline_id_regread.sv
// ---------------------------------------------------------------------------
// pipeline_id_regread : ID-stage operand read, EX/MEM forwarding, load-use stall, ID/EX latch
// Revision            : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_id_regread #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1_ID,
  input  logic [AW-1:0]   rs2_ID,
  input  logic            rs1_used_ID,
  input  logic            rs2_used_ID,
  input  logic            valid_ID,
  input  logic            flush_ID,
  input  logic [AW-1:0]   rd_EX,
  input  logic            reg_write_EX,
  input  logic [1:0]      rf_wr_sel_EX,
  input  logic [XLEN-1:0] fwd_data_EX,
  input  logic [AW-1:0]   rd_MEM,
  input  logic            reg_write_MEM,
  input  logic [XLEN-1:0] fwd_data_MEM,
  input  logic [AW-1:0]   rd_WB,
  input  logic            reg_write_WB,
  input  logic [XLEN-1:0] write_data_WB,
  output logic            stall_ID,
  output logic [XLEN-1:0] rs1_data_EX,
  output logic [XLEN-1:0] rs2_data_EX,
  output logic [AW-1:0]   rs1_EX,
  output logic [AW-1:0]   rs2_EX,
  output logic            valid_EX
);

  import pipeline_pkg::*;

  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic [XLEN-1:0] op1;
  logic [XLEN-1:0] op2;
  logic            ex_is_load;
  logic            ex_fwd_ok;
  logic            bubble;

  regfile_2r1w #(
    .RF_XLEN (XLEN),
    .RF_NREG (NREG),
    .RF_AW   (AW)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .ra1   (rs1_ID),
    .ra2   (rs2_ID),
    .we    (reg_write_WB),
    .wa    (rd_WB),
    .wd    (write_data_WB),
    .rd1   (rf_rd1),
    .rd2   (rf_rd2)
  );

  // A load in EX has no data yet, so it must never be forwarded; the stall covers it.
  assign ex_is_load = (rf_wr_sel_EX == RF_WR_SEL_MEM);
  assign ex_fwd_ok  = reg_write_EX && !ex_is_load;

  function automatic logic [XLEN-1:0] fwd_mux(
    input logic [AW-1:0]   addr,
    input logic [XLEN-1:0] rf_val,
    input logic            ex_ok,
    input logic [AW-1:0]   ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            mem_we,
    input logic [AW-1:0]   mem_rd,
    input logic [XLEN-1:0] mem_data
  );
    if (addr == '0)                          return '0;
    else if (ex_ok && (ex_rd == addr))       return ex_data;
    else if (mem_we && (mem_rd == addr))     return mem_data;
    else                                     return rf_val;
  endfunction

  assign op1 = fwd_mux(rs1_ID, rf_rd1, ex_fwd_ok, rd_EX, fwd_data_EX,
                       reg_write_MEM, rd_MEM, fwd_data_MEM);
  assign op2 = fwd_mux(rs2_ID, rf_rd2, ex_fwd_ok, rd_EX, fwd_data_EX,
                       reg_write_MEM, rd_MEM, fwd_data_MEM);

  assign stall_ID = reset && valid_ID && reg_write_EX && ex_is_load && (rd_EX != '0)
                    && ((rs1_used_ID && (rd_EX == rs1_ID)) ||
                        (rs2_used_ID && (rd_EX == rs2_ID)));

  assign bubble = flush_ID || stall_ID || !valid_ID;

  always_ff @(posedge clk) begin
    if (!reset || bubble) begin
      valid_EX    <= 1'b0;
      rs1_data_EX <= '0;
      rs2_data_EX <= '0;
      rs1_EX      <= '0;
      rs2_EX      <= '0;
    end else begin
      valid_EX    <= 1'b1;
      rs1_data_EX <= op1;
      rs2_data_EX <= op2;
      rs1_EX      <= rs1_ID;
      rs2_EX      <= rs2_ID;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_id_regread.sv
// ---------------------------------------------------------------------------
// tb_pipeline_id_regread : directed stimulus with a queued scoreboard for the ID/EX latch
// Revision               : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipeline_id_regread;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1_ID, rs2_ID, rd_EX, rd_MEM, rd_WB;
  logic        rs1_used_ID, rs2_used_ID, valid_ID, flush_ID;
  logic        reg_write_EX, reg_write_MEM, reg_write_WB;
  logic [1:0]  rf_wr_sel_EX;
  logic [63:0] fwd_data_EX, fwd_data_MEM, write_data_WB;
  logic        stall_ID;
  logic [63:0] rs1_data_EX, rs2_data_EX;
  logic [4:0]  rs1_EX, rs2_EX;
  logic        valid_EX;

  typedef struct {
    int          due;
    logic        v;
    logic [63:0] d1;
    logic [63:0] d2;
    logic [4:0]  a1;
    logic [4:0]  a2;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  pipeline_id_regread dut (
    .clk           (clk),
    .reset         (reset),
    .rs1_ID        (rs1_ID),
    .rs2_ID        (rs2_ID),
    .rs1_used_ID   (rs1_used_ID),
    .rs2_used_ID   (rs2_used_ID),
    .valid_ID      (valid_ID),
    .flush_ID      (flush_ID),
    .rd_EX         (rd_EX),
    .reg_write_EX  (reg_write_EX),
    .rf_wr_sel_EX  (rf_wr_sel_EX),
    .fwd_data_EX   (fwd_data_EX),
    .rd_MEM        (rd_MEM),
    .reg_write_MEM (reg_write_MEM),
    .fwd_data_MEM  (fwd_data_MEM),
    .rd_WB         (rd_WB),
    .reg_write_WB  (reg_write_WB),
    .write_data_WB (write_data_WB),
    .stall_ID      (stall_ID),
    .rs1_data_EX   (rs1_data_EX),
    .rs2_data_EX   (rs2_data_EX),
    .rs1_EX        (rs1_EX),
    .rs2_EX        (rs2_EX),
    .valid_EX      (valid_EX)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare the latched ID/EX outputs against the queued expectation.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (e.due < cyc) begin
        fails++;
        $display("FAIL missed_slot due=%0d now=%0d", e.due, cyc);
      end else if (valid_EX !== e.v || rs1_data_EX !== e.d1 || rs2_data_EX !== e.d2 ||
                   rs1_EX !== e.a1 || rs2_EX !== e.a2) begin
        fails++;
        $display("FAIL id_ex cyc=%0d got v=%0b d1=%h d2=%h a1=%0d a2=%0d want v=%0b d1=%h d2=%h a1=%0d a2=%0d",
                 cyc, valid_EX, rs1_data_EX, rs2_data_EX, rs1_EX, rs2_EX,
                 e.v, e.d1, e.d2, e.a1, e.a2);
      end
    end
  end

  task automatic idle();
    rs1_ID = 0; rs2_ID = 0; rs1_used_ID = 0; rs2_used_ID = 0;
    valid_ID = 0; flush_ID = 0;
    rd_EX = 0; reg_write_EX = 0; rf_wr_sel_EX = 2'b00; fwd_data_EX = 0;
    rd_MEM = 0; reg_write_MEM = 0; fwd_data_MEM = 0;
    rd_WB = 0; reg_write_WB = 0; write_data_WB = 0;
  endtask

  task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
    valid_ID = 1; rs1_ID = a1; rs2_ID = a2; rs1_used_ID = 1; rs2_used_ID = 1;
  endtask

  // Inputs are already applied; check the combinational stall, queue the latch result, advance.
  task automatic step(input logic st, input logic v, input logic [63:0] d1,
                      input logic [63:0] d2, input logic [4:0] a1, input logic [4:0] a2);
    exp_t e;
    #1;
    tests++;
    if (stall_ID !== st) begin
      fails++;
      $display("FAIL stall_ID cyc=%0d got=%0b want=%0b", cyc, stall_ID, st);
    end
    e.due = cyc + 1; e.v = v; e.d1 = d1; e.d2 = d2; e.a1 = a1; e.a2 = a2;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    @(posedge clk); #1;

    // Reset cycle: WB write dropped, load-use pattern present but stall forced low.
    write_data_WB = 64'h77; rd_WB = 3; reg_write_WB = 1;
    rd(9, 0); rd_EX = 9; reg_write_EX = 1; rf_wr_sel_EX = 2'b11;
    step(0, 0, 0, 0, 0, 0);
    reset = 1'b1; idle();

    rd(5, 6);                                            step(0, 1, 0, 0, 5, 6);
    rd(3, 0);                                            step(0, 1, 0, 0, 3, 0);
    rd(0, 0); rd_WB = 0; reg_write_WB = 1; write_data_WB = 64'hDEAD;
                                                         step(0, 1, 0, 0, 0, 0);
    idle(); rd(0, 0);                                    step(0, 1, 0, 0, 0, 0);

    // WB write-first bypass, then the stored value.
    rd(3, 0); rd_WB = 3; reg_write_WB = 1; write_data_WB = 64'h1234;
                                                         step(0, 1, 64'h1234, 0, 3, 0);
    idle(); rd(3, 3);                                    step(0, 1, 64'h1234, 64'h1234, 3, 3);

    // Forwarding priority EX > MEM > WB > array.
    rd(0, 7);
    rd_EX = 7;  reg_write_EX = 1;  rf_wr_sel_EX = 2'b10; fwd_data_EX = 64'hAA;
    rd_MEM = 7; reg_write_MEM = 1; fwd_data_MEM = 64'hBB;
    rd_WB = 7;  reg_write_WB = 1;  write_data_WB = 64'hCC;
                                                         step(0, 1, 0, 64'hAA, 0, 7);
    reg_write_EX = 0;                                    step(0, 1, 0, 64'hBB, 0, 7);
    reg_write_MEM = 0;                                   step(0, 1, 0, 64'hCC, 0, 7);
    idle(); rd(7, 0);                                    step(0, 1, 64'hCC, 0, 7, 0);

    // EX load on an unused port: no stall, load data never forwarded.
    idle(); rd(0, 7); rs2_used_ID = 0;
    rd_EX = 7; reg_write_EX = 1; rf_wr_sel_EX = 2'b11; fwd_data_EX = 64'hEE;
                                                         step(0, 1, 0, 64'hCC, 0, 7);

    // Boundary register x31.
    idle(); rd(31, 31); rd_WB = 31; reg_write_WB = 1; write_data_WB = 64'hFFFF_FFFF_FFFF_FFFF;
                                                         step(0, 1, '1, '1, 31, 31);

    // Load-use on rs1, then the load has moved to MEM.
    idle(); rd(9, 0); rd_EX = 9; reg_write_EX = 1; rf_wr_sel_EX = 2'b11;
                                                         step(1, 0, 0, 0, 0, 0);
    idle(); rd(9, 0); rd_MEM = 9; reg_write_MEM = 1; fwd_data_MEM = 64'h55;
                                                         step(0, 1, 64'h55, 0, 9, 0);
    // Load-use on rs2; rs1 match with rs1_used low does not stall.
    idle(); rd(0, 9); rd_EX = 9; reg_write_EX = 1; rf_wr_sel_EX = 2'b11;
                                                         step(1, 0, 0, 0, 0, 0);
    rd(9, 0); rs1_used_ID = 0;                           step(0, 1, 0, 0, 9, 0);
    // Load to x0 and invalid ID never stall.
    idle(); rd(0, 0); rd_EX = 0; reg_write_EX = 1; rf_wr_sel_EX = 2'b11;
                                                         step(0, 1, 0, 0, 0, 0);
    idle(); rd(9, 9); valid_ID = 0; rd_EX = 9; reg_write_EX = 1; rf_wr_sel_EX = 2'b11;
                                                         step(0, 0, 0, 0, 0, 0);

    // Flush with and without a concurrent stall.
    idle(); rd(9, 0); rd_EX = 9; reg_write_EX = 1; rf_wr_sel_EX = 2'b11; flush_ID = 1;
                                                         step(1, 0, 0, 0, 0, 0);
    idle(); rd(3, 31); flush_ID = 1;                     step(0, 0, 0, 0, 0, 0);

    // Reset asserted mid-stall clears everything.
    idle(); rd(9, 0); rd_EX = 9; reg_write_EX = 1; rf_wr_sel_EX = 2'b11; reset = 1'b0;
                                                         step(0, 0, 0, 0, 0, 0);
    reset = 1'b1; idle(); rd(3, 7);                      step(0, 1, 0, 0, 3, 7);
    rd(31, 0);                                           step(0, 1, 0, 0, 31, 0);
    idle();

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
